uart_command_decoder: RTL and testbench

UART_COMMAND_DECODER -- requirements
Module: uart_command_decoder

---
 rtl/uart_command_decoder_if.sv | 24 ++
 rtl/uart_command_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_uart_command_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_command_decoder_if.sv
// Signal bundle between the UART receiver/transmitter, the entropy source and
// the command decoder. The decoder uses the slave modport; its driver uses master.
interface uart_command_decoder_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       word_ready;
  logic [7:0] entropy_byte;
  logic       tx_busy;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       soft_reset;
  logic       streaming;

  modport master (
    output received, rx_byte, recv_error, word_ready, entropy_byte, tx_busy,
    input  transmit, tx_byte, soft_reset, streaming
  );

  modport slave (
    input  received, rx_byte, recv_error, word_ready, entropy_byte, tx_busy,
    output transmit, tx_byte, soft_reset, streaming
  );
endinterface

// File: rtl/uart_command_decoder.sv
// UART command decoder: parses single-byte commands and 'n'+16-bit burst counts,
// arbitrates status/ack/entropy bytes onto the transmitter. Define UART_CMD_ACK_EN for ack/nak replies.
module uart_command_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 32000000
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_command_decoder_if.slave bus
);

  localparam logic [1:0] P_CMD   = 2'd0;
  localparam logic [1:0] P_HI    = 2'd1;
  localparam logic [1:0] P_LO    = 2'd2;
  localparam logic [1:0] M_STOP  = 2'd0;
  localparam logic [1:0] M_CONT  = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;

  localparam int unsigned    TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    parser,     parser_nxt;
  logic [1:0]    mode,       mode_nxt;
  logic [15:0]   count,      count_nxt;
  logic [7:0]    count_hi,   count_hi_nxt;
  logic [TW-1:0] timer,      timer_nxt;
  logic          err,        err_nxt;
  logic          status_pend, status_pend_nxt;
  logic          transmit_reg, transmit_nxt;
  logic [7:0]    tx_byte_reg,  tx_byte_nxt;
  logic          soft_reset_reg, soft_reset_nxt;
  logic          streaming_reg,  streaming_nxt;
  logic          eligible;
`ifdef UART_CMD_ACK_EN
  logic          ack_pend,   ack_pend_nxt;
  logic [7:0]    ack_byte,   ack_byte_nxt;
`endif

  function automatic logic [7:0] status_byte(input logic e, input logic [1:0] p,
                                             input logic [1:0] m);
    return {4'hA, e, (p != P_CMD), (m == M_BURST), (m == M_CONT)};
  endfunction

  assign eligible = !bus.tx_busy && !transmit_reg;

  always_comb begin
    parser_nxt      = parser;
    mode_nxt        = mode;
    count_nxt       = count;
    count_hi_nxt    = count_hi;
    timer_nxt       = timer;
    err_nxt         = err;
    status_pend_nxt = status_pend;
    transmit_nxt    = 1'b0;
    tx_byte_nxt     = tx_byte_reg;
    soft_reset_nxt  = 1'b0;
`ifdef UART_CMD_ACK_EN
    ack_pend_nxt    = ack_pend;
    ack_byte_nxt    = ack_byte;
`endif

    // Transmit arbitration runs first so that commands arriving on the same edge override it.
    if (eligible) begin
      if (status_pend) begin
        transmit_nxt    = 1'b1;
        tx_byte_nxt     = status_byte(err, parser, mode);
        status_pend_nxt = 1'b0;
        err_nxt         = 1'b0;
      end
`ifdef UART_CMD_ACK_EN
      else if (ack_pend) begin
        transmit_nxt = 1'b1;
        tx_byte_nxt  = ack_byte;
        ack_pend_nxt = 1'b0;
      end
`endif
      else if (bus.word_ready && (mode != M_STOP)) begin
        transmit_nxt = 1'b1;
        tx_byte_nxt  = bus.entropy_byte;
        if (mode == M_BURST) begin
          count_nxt = count - 16'd1;
          if (count == 16'd1) mode_nxt = M_STOP;
        end
      end
    end

    if (bus.received || bus.recv_error || (parser == P_CMD)) begin
      timer_nxt = '0;
    end else if (timer == T_LAST) begin
      timer_nxt  = '0;
      parser_nxt = P_CMD;
    end else begin
      timer_nxt = timer + TW'(1);
    end

    if (bus.recv_error) begin
      parser_nxt   = P_CMD;
      count_hi_nxt = '0;
      err_nxt      = 1'b1;
    end else if (bus.received) begin
      case (parser)
        P_CMD: begin
          case (bus.rx_byte)
            8'h72: begin
              soft_reset_nxt  = 1'b1;
              mode_nxt        = M_STOP;
              count_nxt       = '0;
              status_pend_nxt = 1'b0;
`ifdef UART_CMD_ACK_EN
              ack_pend_nxt = 1'b1; ack_byte_nxt = 8'h06;
`endif
            end
            8'h63: begin
              mode_nxt  = M_CONT;
              count_nxt = '0;
`ifdef UART_CMD_ACK_EN
              ack_pend_nxt = 1'b1; ack_byte_nxt = 8'h06;
`endif
            end
            8'h73: begin
              mode_nxt  = M_STOP;
              count_nxt = '0;
`ifdef UART_CMD_ACK_EN
              ack_pend_nxt = 1'b1; ack_byte_nxt = 8'h06;
`endif
            end
            // A request that lands while one is still pending merges into it.
            8'h71: if (!status_pend) status_pend_nxt = 1'b1;
            8'h6E: parser_nxt = P_HI;
            default: begin
`ifdef UART_CMD_ACK_EN
              ack_pend_nxt = 1'b1; ack_byte_nxt = 8'h15;
`endif
            end
          endcase
        end
        P_HI: begin
          count_hi_nxt = bus.rx_byte;
          parser_nxt   = P_LO;
        end
        P_LO: begin
          parser_nxt = P_CMD;
          if ({count_hi, bus.rx_byte} == 16'd0) begin
            mode_nxt  = M_STOP;
            count_nxt = '0;
          end else begin
            mode_nxt  = M_BURST;
            count_nxt = {count_hi, bus.rx_byte};
          end
`ifdef UART_CMD_ACK_EN
          ack_pend_nxt = 1'b1; ack_byte_nxt = 8'h06;
`endif
        end
        default: parser_nxt = P_CMD;
      endcase
    end

    streaming_nxt = (mode_nxt != M_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parser         <= P_CMD;
      mode           <= M_STOP;
      count          <= '0;
      count_hi       <= '0;
      timer          <= '0;
      err            <= 1'b0;
      status_pend    <= 1'b0;
      transmit_reg   <= 1'b0;
      tx_byte_reg    <= 8'h00;
      soft_reset_reg <= 1'b0;
      streaming_reg  <= 1'b0;
`ifdef UART_CMD_ACK_EN
      ack_pend       <= 1'b0;
      ack_byte       <= 8'h00;
`endif
    end else begin
      parser         <= parser_nxt;
      mode           <= mode_nxt;
      count          <= count_nxt;
      count_hi       <= count_hi_nxt;
      timer          <= timer_nxt;
      err            <= err_nxt;
      status_pend    <= status_pend_nxt;
      transmit_reg   <= transmit_nxt;
      tx_byte_reg    <= tx_byte_nxt;
      soft_reset_reg <= soft_reset_nxt;
      streaming_reg  <= streaming_nxt;
`ifdef UART_CMD_ACK_EN
      ack_pend       <= ack_pend_nxt;
      ack_byte       <= ack_byte_nxt;
`endif
    end
  end

  assign bus.transmit   = transmit_reg;
  assign bus.tx_byte    = tx_byte_reg;
  assign bus.soft_reset = soft_reset_reg;
  assign bus.streaming  = streaming_reg;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Scenario bench for uart_command_decoder: expected transmit bytes are queued as
// stimulus is applied and matched against captured transmit strobes.
module tb_uart_command_decoder;
  localparam int TIMEOUT = 60;
`ifdef UART_CMD_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_command_decoder_if bus();
  uart_command_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] last_sent = 8'h00;
  int sr_pulses = 0;
  int model_mode = 0;   // 0 stop, 1 cont, 2 burst
  int model_count = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.transmit) obs_q.push_back(bus.tx_byte);
      if (bus.soft_reset) sr_pulses++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte = b;
    bus.received = 1'b1;
    step(1);
    bus.received = 1'b0;
    step(4);
  endtask

  task automatic expect_ack(input logic [7:0] code);
    if (ACK_EN) exp_q.push_back(code);
  endtask

  task automatic pulse_entropy();
    logic [7:0] b;
    b = 8'($urandom_range(255));
    if (model_mode != 0) begin
      exp_q.push_back(b);
      if (model_mode == 2) begin
        model_count--;
        if (model_count == 0) model_mode = 0;
      end
    end
    bus.entropy_byte = b;
    bus.word_ready = 1'b1;
    step(1);
    bus.word_ready = 1'b0;
    step(39);
  endtask

  task automatic check_scoreboard(input string tag);
    logic [7:0] got, want;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected tx_byte=%02h, required no transmit", tag, got);
      end else begin
        want = exp_q.pop_front();
        last_sent = want;
        if (got !== want) begin
          failures++;
          $display("FAIL %s tx_byte=%02h required=%02h", tag, got, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_bytes=%0d required=0 next=%02h", tag, exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.received = 1'b0; bus.rx_byte = 8'h00; bus.recv_error = 1'b0;
    bus.word_ready = 1'b0; bus.entropy_byte = 8'h00; bus.tx_busy = 1'b0;
    rst_n = 1'b0;
    step(3);
    checks++; if (bus.transmit !== 1'b0) begin failures++; $display("FAIL reset_transmit got=%b req=0", bus.transmit); end
    checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%02h req=00", bus.tx_byte); end
    checks++; if (bus.soft_reset !== 1'b0) begin failures++; $display("FAIL reset_soft_reset got=%b req=0", bus.soft_reset); end
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL reset_streaming got=%b req=0", bus.streaming); end
    rst_n = 1'b1;
    step(3);
    check_scoreboard("reset_idle");
  endtask

  task automatic test_cont();
    expect_ack(8'h06);
    send_byte(8'h63);
    model_mode = 1;
    checks++; if (bus.streaming !== 1'b1) begin failures++; $display("FAIL cont_streaming got=%b req=1", bus.streaming); end
    exp_q.push_back(8'hA1);
    send_byte(8'h71);
    for (int i = 0; i < 4; i++) pulse_entropy();
    check_scoreboard("cont_stream");
    checks++; if (bus.tx_byte !== last_sent) begin failures++; $display("FAIL cont_tx_hold got=%02h req=%02h", bus.tx_byte, last_sent); end
    expect_ack(8'h06);
    send_byte(8'h73);
    model_mode = 0;
    for (int i = 0; i < 3; i++) pulse_entropy();
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL stop_streaming got=%b req=0", bus.streaming); end
    check_scoreboard("cont_stop");
  endtask

  task automatic test_burst();
    send_byte(8'h6E); send_byte(8'h00);
    expect_ack(8'h06);
    send_byte(8'h05);
    model_mode = 2; model_count = 5;
    exp_q.push_back(8'hA2);
    send_byte(8'h71);
    for (int i = 0; i < 7; i++) pulse_entropy();
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL burst_end_streaming got=%b req=0", bus.streaming); end
    check_scoreboard("burst5");
    send_byte(8'h6E); send_byte(8'h00);
    expect_ack(8'h06);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) pulse_entropy();
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL burst0_streaming got=%b req=0", bus.streaming); end
    check_scoreboard("burst0");
  endtask

  task automatic test_timeout();
    send_byte(8'h6E); send_byte(8'h12);
    step(TIMEOUT + 1);
    exp_q.push_back(8'hA0);
    send_byte(8'h71);
    check_scoreboard("timeout_status");
    expect_ack(8'h06);
    send_byte(8'h63);
    model_mode = 1;
    checks++; if (bus.streaming !== 1'b1) begin failures++; $display("FAIL timeout_cont got=%b req=1", bus.streaming); end
    pulse_entropy();
    expect_ack(8'h06);
    send_byte(8'h73);
    model_mode = 0;
    check_scoreboard("timeout_cont");
  endtask

  task automatic test_error();
    send_byte(8'h6E);
    bus.rx_byte = 8'h63; bus.received = 1'b1; bus.recv_error = 1'b1;
    step(1);
    bus.received = 1'b0; bus.recv_error = 1'b0;
    step(4);
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL error_byte_dropped streaming=%b req=0", bus.streaming); end
    exp_q.push_back(8'hA8);
    send_byte(8'h71);
    check_scoreboard("error_status");
    exp_q.push_back(8'hA0);
    send_byte(8'h71);
    check_scoreboard("error_cleared");
  endtask

  task automatic test_soft_reset();
    send_byte(8'h6E); send_byte(8'h01);
    expect_ack(8'h06);
    send_byte(8'h00);
    model_mode = 2; model_count = 256;
    pulse_entropy(); pulse_entropy();
    sr_pulses = 0;
    expect_ack(8'h06);
    send_byte(8'h72);
    model_mode = 0;
    checks++; if (sr_pulses !== 1) begin failures++; $display("FAIL soft_reset_cycles got=%0d req=1", sr_pulses); end
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL soft_reset_streaming got=%b req=0", bus.streaming); end
    pulse_entropy(); pulse_entropy();
    check_scoreboard("soft_reset");
  endtask

  task automatic test_ack_nak();
    expect_ack(8'h15);
    send_byte(8'h41);
    check_scoreboard("nak_0x41");
  endtask

  task automatic test_back_to_back();
    bus.rx_byte = 8'h71; bus.received = 1'b1;
    step(2);
    bus.received = 1'b0;
    step(4);
    exp_q.push_back(8'hA0);
    check_scoreboard("double_q");
    bus.tx_busy = 1'b1;
    send_byte(8'h71);
    step(10);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL busy_hold strobes=%0d req=0", obs_q.size()); obs_q.delete(); end
    bus.tx_busy = 1'b0;
    exp_q.push_back(8'hA0);
    step(4);
    check_scoreboard("busy_release");
  endtask

  task automatic test_async_reset();
    expect_ack(8'h06);
    send_byte(8'h63);
    check_scoreboard("async_pre");
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.streaming !== 1'b0) begin failures++; $display("FAIL async_reset_streaming got=%b req=0", bus.streaming); end
    step(2);
    rst_n = 1'b1;
    model_mode = 0;
    step(2);
    pulse_entropy();
    check_scoreboard("async_post");
  endtask

  initial begin
    test_reset();
    test_cont();
    test_burst();
    test_timeout();
    test_error();
    test_soft_reset();
    test_ack_nak();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
